// File: rtl/lighthouse_sensor_arbiter.sv
// Round-robin arbiter that funnels snapshotted lighthouse sweep records from
// NUM_SENSORS decoders into one tagged valid/ready stream, counting lost strobes.
module lighthouse_sensor_arbiter #(
    parameter int NUM_SENSORS = 4,
    parameter int WIDTH       = 24,
    parameter int ID_BITS     = 2,
    parameter int DROP_BITS   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SENSORS*WIDTH-1:0]   sync0,
    input  logic [NUM_SENSORS*WIDTH-1:0]   sync1,
    input  logic [NUM_SENSORS*WIDTH-1:0]   sweep,
    input  logic [NUM_SENSORS-1:0]         sweep_strobe,
    output logic [ID_BITS+3*WIDTH-1:0]     out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_SENSORS-1:0]         overflow,
    input  logic                           clear_overflow,
    output logic [DROP_BITS-1:0]           drop_count
);

    localparam int REC_W = 3 * WIDTH;
    localparam int OUT_W = ID_BITS + REC_W;
    localparam int CNT_W = DROP_BITS + 4;
    localparam logic [CNT_W-1:0] DROP_MAX = {{4{1'b0}}, {DROP_BITS{1'b1}}};

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                 state_r, state_next_s;
    logic [NUM_SENSORS-1:0] pending_r, pending_next_s;
    logic [REC_W-1:0]       snap_r [NUM_SENSORS];
    logic [ID_BITS-1:0]     rr_last_r, rr_last_next_s;
    logic [OUT_W-1:0]       out_data_r, out_data_next_s;
    logic [NUM_SENSORS-1:0] overflow_r, overflow_next_s;
    logic [DROP_BITS-1:0]   drop_count_r, drop_count_next_s;

    logic                   found_hi_s, found_lo_s, any_pending_s, load_s;
    logic [ID_BITS-1:0]     win_hi_s, win_lo_s, winner_s;
    logic [REC_W-1:0]       win_snap_s;
    logic [NUM_SENSORS-1:0] capture_s, drop_s, granted_s;
    logic [CNT_W-1:0]       drop_num_s, drop_base_s, drop_sum_s;

    // Winner search: first pending channel above rr_last, else lowest pending channel (wrap).
    always_comb begin
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        win_hi_s   = '0;
        win_lo_s   = '0;
        win_snap_s = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (pending_r[i] && !found_lo_s) begin
                found_lo_s = 1'b1;
                win_lo_s   = ID_BITS'(i);
            end else begin
                found_lo_s = found_lo_s;
            end
            if (pending_r[i] && !found_hi_s && (ID_BITS'(i) > rr_last_r)) begin
                found_hi_s = 1'b1;
                win_hi_s   = ID_BITS'(i);
            end else begin
                found_hi_s = found_hi_s;
            end
        end
        winner_s      = found_hi_s ? win_hi_s : win_lo_s;
        any_pending_s = found_lo_s;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (ID_BITS'(i) == winner_s) begin
                win_snap_s = snap_r[i];
            end else begin
                win_snap_s = win_snap_s;
            end
        end
        load_s = any_pending_s && ((state_r == ST_EMPTY) || out_ready);
    end

    // Per-channel capture/drop decision; a granted channel may be refilled in the same cycle.
    always_comb begin
        capture_s      = '0;
        drop_s         = '0;
        granted_s      = '0;
        pending_next_s = pending_r;
        drop_num_s     = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            granted_s[i] = load_s && (winner_s == ID_BITS'(i));
            if (sweep_strobe[i] && (!pending_r[i] || granted_s[i])) begin
                capture_s[i] = 1'b1;
            end else if (sweep_strobe[i]) begin
                drop_s[i] = 1'b1;
            end else begin
                capture_s[i] = 1'b0;
            end
            if (capture_s[i]) begin
                pending_next_s[i] = 1'b1;
            end else if (granted_s[i]) begin
                pending_next_s[i] = 1'b0;
            end else begin
                pending_next_s[i] = pending_r[i];
            end
            drop_num_s = drop_num_s + CNT_W'(drop_s[i]);
        end
    end

    // Sticky overflow and saturating drop counter; clear acts on the old value only.
    always_comb begin
        if (clear_overflow) begin
            drop_base_s     = '0;
            overflow_next_s = drop_s;
        end else begin
            drop_base_s     = CNT_W'(drop_count_r);
            overflow_next_s = overflow_r | drop_s;
        end
        drop_sum_s = drop_base_s + drop_num_s;
        if (drop_sum_s > DROP_MAX) begin
            drop_count_next_s = '1;
        end else begin
            drop_count_next_s = drop_sum_s[DROP_BITS-1:0];
        end
    end

    // Output stage next-state: load on empty or handshake, hold data while stalled.
    always_comb begin
        state_next_s    = state_r;
        out_data_next_s = out_data_r;
        rr_last_next_s  = rr_last_r;
        case (state_r)
            ST_EMPTY: begin
                if (load_s) begin
                    state_next_s    = ST_FULL;
                    out_data_next_s = {winner_s, win_snap_s};
                    rr_last_next_s  = winner_s;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (load_s) begin
                    state_next_s    = ST_FULL;
                    out_data_next_s = {winner_s, win_snap_s};
                    rr_last_next_s  = winner_s;
                end else if (out_ready) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_EMPTY;
            pending_r    <= '0;
            rr_last_r    <= ID_BITS'(NUM_SENSORS - 1);
            out_data_r   <= '0;
            overflow_r   <= '0;
            drop_count_r <= '0;
        end else begin
            state_r      <= state_next_s;
            pending_r    <= pending_next_s;
            rr_last_r    <= rr_last_next_s;
            out_data_r   <= out_data_next_s;
            overflow_r   <= overflow_next_s;
            drop_count_r <= drop_count_next_s;
        end
    end

    // Snapshot registers, one per channel.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (reset) begin
                snap_r[i] <= '0;
            end else if (capture_s[i]) begin
                snap_r[i] <= {sync0[i*WIDTH +: WIDTH], sync1[i*WIDTH +: WIDTH],
                              sweep[i*WIDTH +: WIDTH]};
            end else begin
                snap_r[i] <= snap_r[i];
            end
        end
    end

    assign out_valid  = (state_r == ST_FULL);
    assign out_data   = out_data_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_lighthouse_sensor_arbiter.sv
// Directed self-checking bench for lighthouse_sensor_arbiter: latency, round-robin order,
// drops/overflow, re-strobe on grant and reset while busy.
module tb_lighthouse_sensor_arbiter;
    localparam int N  = 4;
    localparam int W  = 24;
    localparam int IB = 2;
    localparam int DB = 16;
    localparam int OW = IB + 3 * W;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*W-1:0]  sync0, sync1, sweep;
    logic [N-1:0]    sweep_strobe;
    logic [OW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    overflow;
    logic            clear_overflow;
    logic [DB-1:0]   drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    lighthouse_sensor_arbiter #(.NUM_SENSORS(N), .WIDTH(W), .ID_BITS(IB), .DROP_BITS(DB)) dut (
        .clk(clk), .reset(reset), .sync0(sync0), .sync1(sync1), .sweep(sweep),
        .sweep_strobe(sweep_strobe), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .clear_overflow(clear_overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        sync0[ch*W +: W] = a;
        sync1[ch*W +: W] = b;
        sweep[ch*W +: W] = c;
    endtask

    function automatic logic [OW-1:0] rec(input logic [IB-1:0] id, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] c);
        return {id, a, b, c};
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        sync0 = '0; sync1 = '0; sweep = '0; sweep_strobe = '0;
        out_ready = 1'b0; clear_overflow = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_cmp++; if (overflow !== 4'b0000) begin n_bad++; $display("FAIL reset_overflow: got %b want 0000", overflow); end
        n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    endtask

    task automatic test_single;
        out_ready = 1'b1;
        set_ch(0, 24'h001000, 24'h002000, 24'h000400);
        sweep_strobe = 4'b0001;
        step();
        sweep_strobe = 4'b0000;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_t1: got %0b want 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_t2_valid: got %0b want 1", out_valid); end
        n_cmp++; if (out_data !== rec(2'd0, 24'h001000, 24'h002000, 24'h000400)) begin
            n_bad++; $display("FAIL single_t2_data: got %h want %h", out_data, rec(2'd0, 24'h001000, 24'h002000, 24'h000400)); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_t3: got %0b want 0", out_valid); end
    endtask

    task automatic test_all4;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, 24'h100000 + W'(i), 24'h200000 + W'(i), 24'h000300 + W'(i * 16));
        sweep_strobe = 4'b1111;
        step();
        sweep_strobe = 4'b0000;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL all4_t1: got %0b want 0", out_valid); end
        for (int i = 0; i < N; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== rec(IB'(i), 24'h100000 + W'(i), 24'h200000 + W'(i), 24'h000300 + W'(i * 16))) begin
                n_bad++; $display("FAIL all4_rec%0d: got v=%0b %h want v=1 %h", i, out_valid, out_data,
                                  rec(IB'(i), 24'h100000 + W'(i), 24'h200000 + W'(i), 24'h000300 + W'(i * 16))); end
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL all4_end: got %0b want 0", out_valid); end
        n_cmp++; if (drop_count !== 16'd0 || overflow !== 4'b0000) begin
            n_bad++; $display("FAIL all4_nodrop: got drop=%0d ovf=%b want 0 0000", drop_count, overflow); end
    endtask

    task automatic test_overflow;
        out_ready = 1'b0;
        set_ch(1, 24'h0A0001, 24'h0A0002, 24'h0A0003);
        sweep_strobe = 4'b0010;
        step();
        sweep_strobe = 4'b0000;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== rec(2'd1, 24'h0A0001, 24'h0A0002, 24'h0A0003)) begin
            n_bad++; $display("FAIL ovf_hold_ch1: got v=%0b %h", out_valid, out_data); end
        set_ch(2, 24'h0B0001, 24'h0B0002, 24'h000011);
        sweep_strobe = 4'b0100;
        step();
        set_ch(2, 24'h0B0001, 24'h0B0002, 24'h000022);
        step();
        sweep_strobe = 4'b0000;
        n_cmp++; if (overflow !== 4'b0100) begin n_bad++; $display("FAIL ovf_flag: got %b want 0100", overflow); end
        n_cmp++; if (drop_count !== 16'd1) begin n_bad++; $display("FAIL ovf_drop1: got %0d want 1", drop_count); end
        n_cmp++; if (out_data !== rec(2'd1, 24'h0A0001, 24'h0A0002, 24'h0A0003)) begin
            n_bad++; $display("FAIL ovf_stable: got %h", out_data); end
        set_ch(3, 24'h0C0001, 24'h0C0002, 24'h000055);
        sweep_strobe = 4'b1000;
        step();
        set_ch(2, 24'h0B0001, 24'h0B0002, 24'h000066);
        set_ch(3, 24'h0C0001, 24'h0C0002, 24'h000077);
        sweep_strobe = 4'b1100;
        step();
        sweep_strobe = 4'b0000;
        n_cmp++; if (overflow !== 4'b1100 || drop_count !== 16'd3) begin
            n_bad++; $display("FAIL ovf_multi: got ovf=%b drop=%0d want 1100 3", overflow, drop_count); end
        set_ch(2, 24'h0B0001, 24'h0B0002, 24'h000088);
        sweep_strobe = 4'b0100;
        clear_overflow = 1'b1;
        step();
        sweep_strobe = 4'b0000;
        clear_overflow = 1'b0;
        n_cmp++; if (overflow !== 4'b0100 || drop_count !== 16'd1) begin
            n_bad++; $display("FAIL ovf_clear_drop: got ovf=%b drop=%0d want 0100 1", overflow, drop_count); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== rec(2'd2, 24'h0B0001, 24'h0B0002, 24'h000011)) begin
            n_bad++; $display("FAIL ovf_ch2_old: got v=%0b %h", out_valid, out_data); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== rec(2'd3, 24'h0C0001, 24'h0C0002, 24'h000055)) begin
            n_bad++; $display("FAIL ovf_ch3_old: got v=%0b %h", out_valid, out_data); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || drop_count !== 16'd1) begin
            n_bad++; $display("FAIL ovf_end: got v=%0b drop=%0d want 0 1", out_valid, drop_count); end
    endtask

    task automatic test_rr_order;
        out_ready = 1'b1;
        set_ch(2, 24'h0D0001, 24'h0D0002, 24'h000021);
        sweep_strobe = 4'b0100;
        step();
        set_ch(0, 24'h0E0001, 24'h0E0002, 24'h000001);
        set_ch(3, 24'h0F0001, 24'h0F0002, 24'h000031);
        sweep_strobe = 4'b1001;
        step();
        sweep_strobe = 4'b0000;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== rec(2'd2, 24'h0D0001, 24'h0D0002, 24'h000021)) begin
            n_bad++; $display("FAIL rr_ch2: got v=%0b %h", out_valid, out_data); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== rec(2'd3, 24'h0F0001, 24'h0F0002, 24'h000031)) begin
            n_bad++; $display("FAIL rr_ch3_first: got v=%0b %h", out_valid, out_data); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== rec(2'd0, 24'h0E0001, 24'h0E0002, 24'h000001)) begin
            n_bad++; $display("FAIL rr_ch0_second: got v=%0b %h", out_valid, out_data); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rr_end: got %0b want 0", out_valid); end
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        n_cmp++; if (overflow !== 4'b0000 || drop_count !== 16'd0) begin
            n_bad++; $display("FAIL rr_clear: got ovf=%b drop=%0d want 0000 0", overflow, drop_count); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        set_ch(1, 24'h010001, 24'h010002, 24'h000030);
        sweep_strobe = 4'b0010;
        step();
        sweep_strobe = 4'b0000;
        step(); step(); step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== rec(2'd1, 24'h010001, 24'h010002, 24'h000030)) begin
            n_bad++; $display("FAIL b2b_stall: got v=%0b %h", out_valid, out_data); end
        set_ch(1, 24'h010001, 24'h010002, 24'h000033);
        sweep_strobe = 4'b0010;
        out_ready = 1'b1;
        step();
        sweep_strobe = 4'b0000;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: got %0b want 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== rec(2'd1, 24'h010001, 24'h010002, 24'h000033) || drop_count !== 16'd0) begin
            n_bad++; $display("FAIL b2b_second: got v=%0b %h drop=%0d", out_valid, out_data, drop_count); end
        step();
        out_ready = 1'b0;
        set_ch(0, 24'h020001, 24'h020002, 24'h000002);
        sweep_strobe = 4'b0001;
        step();
        sweep_strobe = 4'b0000;
        step();
        set_ch(1, 24'h030001, 24'h030002, 24'h000040);
        sweep_strobe = 4'b0010;
        step();
        set_ch(1, 24'h030001, 24'h030002, 24'h000041);
        out_ready = 1'b1;
        step();
        sweep_strobe = 4'b0000;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== rec(2'd1, 24'h030001, 24'h030002, 24'h000040)) begin
            n_bad++; $display("FAIL regrant_old: got v=%0b %h", out_valid, out_data); end
        n_cmp++; if (drop_count !== 16'd0 || overflow !== 4'b0000) begin
            n_bad++; $display("FAIL regrant_nodrop: got drop=%0d ovf=%b want 0 0000", drop_count, overflow); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== rec(2'd1, 24'h030001, 24'h030002, 24'h000041)) begin
            n_bad++; $display("FAIL regrant_new: got v=%0b %h", out_valid, out_data); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL regrant_end: got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b0;
        set_ch(0, 24'h040001, 24'h040002, 24'h000003);
        sweep_strobe = 4'b0001;
        step();
        sweep_strobe = 4'b1110;
        step();
        sweep_strobe = 4'b0000;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %0b want 1", out_valid); end
        reset = 1'b1;
        sweep_strobe = 4'b0010;
        step();
        reset = 1'b0;
        sweep_strobe = 4'b0000;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin
            n_bad++; $display("FAIL mid_reset: got v=%0b %h want 0 0", out_valid, out_data); end
        out_ready = 1'b1;
        step(); step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_pending: got %0b want 0", out_valid); end
        set_ch(3, 24'h050001, 24'h050002, 24'h000099);
        sweep_strobe = 4'b1000;
        step();
        sweep_strobe = 4'b0000;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_ch3_t1: got %0b want 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== rec(2'd3, 24'h050001, 24'h050002, 24'h000099)) begin
            n_bad++; $display("FAIL mid_ch3_t2: got v=%0b %h", out_valid, out_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all4();
        test_overflow();
        test_rr_order();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lighthouse_sensor_arbiter.md
Name: lighthouse_sensor_arbiter

Overview:
Shares one downstream record path (timer FIFO → hex UART dump) between NUM_SENSORS lighthouse sweep decoders. Each decoder's (sync0, sync1, sweep) triple is snapshotted when its sweep_strobe fires. A round-robin arbiter then presents one tagged record at a time on a valid/ready output. Lost events are counted, never silently merged.

Parameters:
NUM_SENSORS, 4, number of sweep decoder channels (2..8)
WIDTH, 24, width of each sync0/sync1/sweep timing field in clk cycles
ID_BITS, 2, width of the sensor-id tag; 2**ID_BITS >= NUM_SENSORS is required
DROP_BITS, 16, width of the saturating drop counter

Ports:
clk  input  1  system clock (48 MHz HFOSC domain)
reset  input  1  synchronous, active-high reset
sync0  input  NUM_SENSORS*WIDTH  per-channel sync0 length; channel i occupies bits [i*WIDTH +: WIDTH]
sync1  input  NUM_SENSORS*WIDTH  per-channel sync1 length, same packing
sweep  input  NUM_SENSORS*WIDTH  per-channel sweep time, same packing
sweep_strobe  input  NUM_SENSORS  one-cycle pulse per channel; fields are valid in the same cycle
out_data  output  ID_BITS+3*WIDTH  record {id, sync0, sync1, sweep}, MSB first
out_valid  output  1  out_data holds an unconsumed record
out_ready  input  1  consumer accepts the record when out_valid && out_ready
overflow  output  NUM_SENSORS  sticky per-channel flag: a strobe was dropped
clear_overflow  input  1  one-cycle pulse; clears overflow and drop_count
drop_count  output  DROP_BITS  total dropped strobes, saturating at all-ones

Behaviour:
- Reset: out_valid=0, out_data=0, overflow=0, drop_count=0, all pending=0, rr_last=NUM_SENSORS-1 (so channel 0 wins first). Reset overrides every other input in the same cycle. Records in flight are discarded.
- Per-channel capture: each channel has a 3*WIDTH snapshot register and a pending bit.
  - If sweep_strobe[i] is high and pending[i] is 0 (or is being granted this cycle), latch the fields and set pending[i] next cycle.
  - If sweep_strobe[i] is high while pending[i] is 1 and channel i is not granted this cycle: drop the new event and keep the old snapshot. Set overflow[i] and increment drop_count, saturating.
  - If several channels drop in the same cycle, drop_count increases by the number of dropped strobes, still saturating.
- Output stage states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Load condition: the output register loads when (state==EMPTY) or (out_valid && out_ready), and any pending bit is set.
- Grant selection:
  - The winner is the first pending channel scanning rr_last+1, rr_last+2, ... modulo NUM_SENSORS.
  - On load: out_data={winner id, its snapshot}; pending[winner] clears; rr_last=winner; out_valid=1 next cycle.
  - On a handshake with nothing pending: out_valid=0 next cycle.
  - out_data is held stable while out_valid && !out_ready.
- Throughput and latency:
  - Throughput: one record per clk under continuous out_ready.
  - Latency: strobe at cycle T gives pending at T+1, and out_valid at T+2 at the earliest (EMPTY stage, no competitors).
- Simultaneous grant and re-strobe on the same channel: the old snapshot goes to out_data. The new snapshot is latched and pending stays 1. No drop is counted.
- clear_overflow coinciding with a new drop: the clear wins for the old state. The new drop then sets overflow[i]=1 and drop_count=1.
- Channels with index >= NUM_SENSORS never exist. Id values above NUM_SENSORS-1 never appear.

Test Plan:
- Reset, then strobe ch0 once at cycle 10 with sync0=0x001000, sync1=0x002000, sweep=0x000400, out_ready=1 → out_valid high at cycle 12 only, out_data={2'd0,0x001000,0x002000,0x000400}.
- Strobe all 4 channels in one cycle, out_ready=1 → records on 4 consecutive cycles with ids 0,1,2,3, each carrying its own channel's fields; no drops.
- out_ready=0; strobe ch2 with sweep=0x11, then strobe ch2 again with sweep=0x22 → overflow=4'b0100, drop_count=1. After out_ready=1, a single ch2 record appears with sweep=0x11.
- After a grant to ch2, leave ch0 and ch3 pending → ch3 is granted before ch0. Pulse clear_overflow → overflow=0, drop_count=0.
- Hold out_ready=0 with ch1 presented; strobe ch1 (sweep=0x33) in the handshake cycle once out_ready goes high → old ch1 record accepted, then a second ch1 record with sweep=0x33 follows; drop_count unchanged.
- Assert reset for one cycle while out_valid=1 and 3 channels are pending → next cycle out_valid=0, pending=0, out_data=0. A subsequent ch3 strobe yields id 3 at T+2.
